// File: rtl/dht11_driver.sv
// DHT11 single-wire sensor driver: periodic start pulse, response handshake,
// pulse-width bit decode and checksum validation of the 40-bit frame.
module dht11_driver #(
  parameter int unsigned CLK_FREQ_MHZ   = 50,
  parameter int unsigned POWERUP_MS     = 1000,
  parameter int unsigned READ_PERIOD_MS = 2000,
  parameter int unsigned START_LOW_MS   = 20,
  parameter int unsigned BIT_THRESH_US  = 40,
  parameter int unsigned TIMEOUT_US     = 200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  inout  wire        dht11,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_float,
  output logic [7:0] temperature_int,
  output logic [7:0] temperature_float,
  output logic       data_valid,
  output logic       check_err,
  output logic       busy
);

  localparam int unsigned POWERUP_US = POWERUP_MS * 1000;
  localparam int unsigned PERIOD_US  = READ_PERIOD_MS * 1000;
  localparam int unsigned START_US   = START_LOW_MS * 1000;
  localparam int unsigned MAX_A      = (POWERUP_US > PERIOD_US) ? POWERUP_US : PERIOD_US;
  localparam int unsigned MAX_B      = (MAX_A > START_US) ? MAX_A : START_US;
  localparam int unsigned MAX_US     = (MAX_B > TIMEOUT_US) ? MAX_B : TIMEOUT_US;
  localparam int unsigned US_W       = $clog2(MAX_US + 1);
  localparam int unsigned TICK_W     = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

  typedef enum logic [3:0] {
    POWERUP, WAIT, START, REL, RESP_L, RESP_H, BIT_L, BIT_H, CHECK
  } state_t;

  state_t            state, state_n;
  logic [2:0]        sync;
  logic [TICK_W-1:0] tick_cnt;
  logic [US_W-1:0]   us_cnt;
  logic [39:0]       shreg, shreg_n;
  logic [5:0]        bit_cnt, bit_cnt_n;
  logic [31:0]       data, data_n;
  logic              bus_low, bus_low_n;
  logic              busy_n, valid_n, err_n;

  // Open-drain bus: only ever pulled low, otherwise released to the pull-up
  assign dht11 = bus_low ? 1'b0 : 1'bz;

  assign humidity_int      = data[31:24];
  assign humidity_float    = data[23:16];
  assign temperature_int   = data[15:8];
  assign temperature_float = data[7:0];

  logic              rise_c, fall_c, tick_c;
  logic              pu_done_c, period_done_c, start_done_c, tout_c, bit_one_c;
  logic [US_W:0]     hi_us_c;
  logic [7:0]        sum_c;

  assign rise_c        = sync[1] & ~sync[2];
  assign fall_c        = ~sync[1] & sync[2];
  assign tick_c        = (tick_cnt == TICK_W'(CLK_FREQ_MHZ - 1));
  assign pu_done_c     = tick_c && (us_cnt == US_W'(POWERUP_US - 1));
  assign period_done_c = tick_c && (us_cnt == US_W'(PERIOD_US - 1));
  assign start_done_c  = tick_c && (us_cnt == US_W'(START_US - 1));
  assign tout_c        = tick_c && (us_cnt == US_W'(TIMEOUT_US - 1));
  // High time includes the microsecond that completes on the edge cycle itself
  assign hi_us_c       = {1'b0, us_cnt} + (US_W + 1)'(tick_c);
  assign bit_one_c     = (hi_us_c > (US_W + 1)'(BIT_THRESH_US));
  assign sum_c         = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  // Next-state and output decode
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    data_n    = data;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      POWERUP: if (pu_done_c) state_n = START;
      WAIT:    if (period_done_c) state_n = START;
      START:   if (start_done_c) state_n = REL;
      REL: begin
        if (fall_c)      state_n = RESP_L;
        else if (tout_c) begin state_n = WAIT; err_n = 1'b1; end
      end
      RESP_L: begin
        if (rise_c)      state_n = RESP_H;
        else if (tout_c) begin state_n = WAIT; err_n = 1'b1; end
      end
      RESP_H: begin
        if (fall_c) begin
          state_n   = BIT_L;
          bit_cnt_n = 6'd0;
        end else if (tout_c) begin
          state_n = WAIT;
          err_n   = 1'b1;
        end
      end
      BIT_L: begin
        if (rise_c)      state_n = BIT_H;
        else if (tout_c) begin state_n = WAIT; err_n = 1'b1; end
      end
      BIT_H: begin
        if (fall_c) begin
          shreg_n   = {shreg[38:0], bit_one_c};
          bit_cnt_n = bit_cnt + 6'd1;
          state_n   = (bit_cnt == 6'd39) ? CHECK : BIT_L;
        end else if (tout_c) begin
          state_n = WAIT;
          err_n   = 1'b1;
        end
      end
      CHECK: begin
        state_n = WAIT;
        if (sum_c == shreg[7:0]) begin
          data_n  = shreg[39:8];
          valid_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = POWERUP;
    endcase
    bus_low_n = (state_n == START);
    busy_n    = state_n inside {START, REL, RESP_L, RESP_H, BIT_L, BIT_H, CHECK};
  end

  // Registers; the us timebase restarts on every state change so each
  // duration is measured from the moment its state was entered
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= POWERUP;
      sync       <= 3'b111;
      tick_cnt   <= '0;
      us_cnt     <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      data       <= '0;
      bus_low    <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      check_err  <= 1'b0;
    end else begin
      state      <= state_n;
      sync       <= {sync[1:0], dht11};
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      data       <= data_n;
      bus_low    <= bus_low_n;
      busy       <= busy_n;
      data_valid <= valid_n;
      check_err  <= err_n;
      if (state_n != state) begin
        tick_cnt <= '0;
        us_cnt   <= '0;
      end else if (tick_c) begin
        tick_cnt <= '0;
        us_cnt   <= us_cnt + US_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

endmodule

// File: doc/dht11_driver.md
DHT11_DRIVER -- requirements
Module: dht11_driver

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 50, giving the system clock frequency in MHz used to derive a 1 us tick.
REQ-002 SHALL have parameter POWERUP_MS, default 1000, the wait after reset before the first read.
REQ-003 SHALL have parameter READ_PERIOD_MS, default 2000, the interval from the end of one frame to the next start pulse.
REQ-004 SHALL have parameter START_LOW_MS, default 20, the host start-pulse low time.
REQ-005 SHALL have parameter BIT_THRESH_US, default 40, the data-high duration above which a bit decodes as 1.
REQ-006 SHALL have parameter TIMEOUT_US, default 200, the maximum duration of any sensor-driven level.
REQ-007 SHALL have port sys_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-008 SHALL have port sys_rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-009 SHALL have port dht11, inout, 1, the open-drain single-wire bus; it is driven 0 or released to high-Z, never driven 1.
REQ-010 SHALL have port humidity_int, output, 8, the humidity integer byte of the last good frame.
REQ-011 SHALL have port humidity_float, output, 8, the humidity decimal byte of the last good frame.
REQ-012 SHALL have port temperature_int, output, 8, the temperature integer byte of the last good frame.
REQ-013 SHALL have port temperature_float, output, 8, the temperature decimal byte of the last good frame.
REQ-014 SHALL have port data_valid, output, 1, a one-cycle pulse when the four data outputs update.
REQ-015 SHALL have port check_err, output, 1, a one-cycle pulse on a checksum failure or a timeout.
REQ-016 SHALL have port busy, output, 1, high from the start pulse until the frame completes or aborts.

Function
REQ-017 SHALL synchronise the dht11 input through two flops before use; all edge detection SHALL use the synchronised value.
REQ-018 SHALL generate a 1 us tick from a counter wrapping at CLK_FREQ_MHZ-1; all durations SHALL be counted in 1 us ticks.
REQ-019 SHALL implement states POWERUP, WAIT, START, REL, RESP_L, RESP_H, BIT_L, BIT_H, CHECK.
REQ-020 POWERUP SHALL release the bus for POWERUP_MS, then go to START.
REQ-021 START SHALL drive the bus low for START_LOW_MS, set busy, then go to REL.
REQ-022 REL SHALL release the bus and wait for a falling edge, then go to RESP_L.
REQ-023 RESP_L SHALL wait for a rising edge, then go to RESP_H.
REQ-024 RESP_H SHALL wait for a falling edge, clear the bit counter, then go to BIT_L.
REQ-025 BIT_L SHALL wait for a rising edge, clear the high-time counter, then go to BIT_H.
REQ-026 BIT_H SHALL count the high time in us; on a falling edge it SHALL shift in 1 if count > BIT_THRESH_US, else 0, MSB first, into a 40-bit register.
REQ-027 After the 40th bit, BIT_H SHALL go to CHECK; otherwise it SHALL return to BIT_L.
REQ-028 CHECK SHALL compare (byte0+byte1+byte2+byte3) mod 256 with byte4.
REQ-029 On a CHECK match, the four data outputs SHALL load bytes 0..3 and data_valid SHALL pulse in the same cycle.
REQ-030 On a CHECK mismatch, the data outputs SHALL hold and check_err SHALL pulse.
REQ-031 CHECK SHALL then go to WAIT with busy low.
REQ-032 If any of REL, RESP_L, RESP_H, BIT_L or BIT_H exceeds TIMEOUT_US without its expected edge, check_err SHALL pulse, the bus SHALL be released, outputs SHALL hold, and the state SHALL go to WAIT.
REQ-033 WAIT SHALL release the bus for READ_PERIOD_MS, then go to START; reads repeat indefinitely.
REQ-034 The last data bit's trailing sensor low SHALL be ignored: no edge is expected after CHECK.

Reset
REQ-035 While sys_rst_n is low at a clock edge: state SHALL be POWERUP, the bus released, all data outputs 0x00, data_valid=0, check_err=0, busy=0, and all counters 0.
REQ-036 Reset asserted mid-frame SHALL abort immediately with no data_valid or check_err pulse; after release, a full POWERUP_MS wait SHALL precede the next start.

Verification
REQ-037 (small parameters) Reset release -> bus stays released for POWERUP_MS, then is low for exactly START_LOW_MS, with busy high.
REQ-038 Sensor model sends bytes 0x37,0x00,0x19,0x05,0x55 -> humidity_int=0x37, humidity_float=0x00, temperature_int=0x19, temperature_float=0x05, with one data_valid pulse.
REQ-039 Same frame with checksum 0x54 -> one check_err pulse; outputs keep their previous values; next start follows READ_PERIOD_MS later.
REQ-040 No sensor response after release -> check_err pulses TIMEOUT_US after release, busy drops, bus released.
REQ-041 Bit highs of 27 us and 70 us, and 40/41 us at the threshold -> decoded 0, 1, 0, 1 respectively.
REQ-042 Reset asserted at bit 20 -> outputs 0x00 next cycle, no pulses, restart after POWERUP_MS.
